// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters (port 0 and port 1).
// A request is accepted in IDLE, its operands are presented to the ALU for
// exactly one cycle (EXEC), and the ALU result/flags are registered and held
// for the requester that issued it until that requester consumes them (RESP).
// Only one operation is in flight at a time.
//
// Configuration macro:
//   ARB_FIXED_PRIO_EN  defined   -> fixed priority, port 0 wins when both valid
//                      undefined -> round-robin between the two ports (default)
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   reqN_valid/ready        request handshake for port N (ready only in IDLE,
//                           only for the granted port)
//   reqN_a, reqN_b, reqN_op operands and opcode for port N
//                           (000 add, 001 sub, 010 and, 011 or, 100 xor,
//                            101 abs, 11x illegal)
//   rspN_valid/ready        response handshake for port N
//   rsp_result/flags/err    registered result, {N,Z,C,V} flags, illegal-op flag
//   alu_a, alu_b, alu_ctrl  drive to the shared ALU (zero outside EXEC)
//   alu_result, alu_flags   combinational ALU outputs, sampled at end of EXEC
//   busy                    high in EXEC and RESP
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,

    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             grant_q, grant_d;     // port that owns the op in flight
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d;

`ifndef ARB_FIXED_PRIO_EN
    // Port granted by the most recent accept. Resets to 1 so that port 0
    // wins the first tie after reset.
    logic             last_grant_q, last_grant_d;
`endif

    logic             any_valid;
    logic             sel;                  // port selected by the arbiter

    // Opcodes 110 and 111 are not ALU operations.
    function automatic logic is_illegal(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    assign any_valid = req0_valid | req1_valid;

    always_comb begin
        sel = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ARB_FIXED_PRIO_EN
            sel = 1'b0;
`else
            sel = ~last_grant_q;
`endif
        end else if (req1_valid) begin
            sel = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state, datapath capture and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        result_d     = result_q;
        flags_d      = flags_q;
        err_d        = err_q;
`ifndef ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        alu_a        = '0;
        alu_b        = '0;
        alu_ctrl     = 3'b000;

        case (state_q)
            ST_IDLE: begin
                // Ready is only raised toward a port that is actually
                // requesting, so an asserted ready always means an accept.
                if (any_valid) begin
                    req0_ready = ~sel;
                    req1_ready = sel;
                    grant_d    = sel;
                    a_d        = sel ? req1_a  : req0_a;
                    b_d        = sel ? req1_b  : req0_b;
                    op_d       = sel ? req1_op : req0_op;
`ifndef ARB_FIXED_PRIO_EN
                    last_grant_d = sel;
`endif
                    state_d    = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (is_illegal(op_q)) begin
                    // Illegal ops never reach the ALU; report a clean zero
                    // result with the error bit set instead.
                    result_d = '0;
                    flags_d  = 4'b0000;
                    err_d    = 1'b1;
                end else begin
                    alu_a    = a_q;
                    alu_b    = b_q;
                    alu_ctrl = op_q;
                    result_d = alu_result;
                    flags_d  = alu_flags;
                    err_d    = 1'b0;
                end
                state_d = ST_RESP;
            end

            ST_RESP: begin
                // Only the owning port's ready is looked at; the other
                // port's ready has no effect.
                rsp0_valid = ~grant_q;
                rsp1_valid = grant_q;
                if ((!grant_q && rsp0_ready) || (grant_q && rsp1_ready)) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 3'b000;
            result_q <= '0;
            flags_q  <= 4'b0000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
